// File: rtl/matrix_pkg.sv
// ============================================================================
// matrix_pkg : shared constants and types for the 8x4 LED matrix scanner
// Revision   : 1.0
// ============================================================================
`default_nettype none

package matrix_pkg;
   localparam int NUM_ROWS = 8;
   localparam int NUM_COLS = 4;
   localparam int COL_W    = 2;

   typedef logic [NUM_ROWS-1:0] row_t;

   typedef enum logic [1:0] {
      SCAN_IDLE  = 2'd0,
      SCAN_BLANK = 2'd1,
      SCAN_ON    = 2'd2
   } scan_state_t;
endpackage

`default_nettype wire

// File: rtl/matrix_scan_ctrl_scan_timer.sv
// ============================================================================
// scan_timer : dwell counter, column index and scan FSM for matrix_scan_ctrl
// Revision   : 1.0
// ============================================================================
`default_nettype none

module scan_timer
   import matrix_pkg::*;
#(
   parameter int DIV_W   = 13,
   parameter int BLANK   = 16,
   parameter int PHASE_W = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   output scan_state_t        state,
   output logic [COL_W-1:0]   col,
   output logic [PHASE_W-1:0] phase,
   output logic               dwell_start,
   output logic               frame_end,
   output logic               frame_start
);

   localparam logic [DIV_W-1:0] BLANK_LAST = DIV_W'(BLANK - 1);
   localparam logic [DIV_W-1:0] DWELL_LAST = '1;

   logic [DIV_W-1:0] dwell;
   logic             dwell_end;

   assign phase       = dwell[PHASE_W-1:0];
   assign dwell_start = (state != SCAN_IDLE) && (dwell == '0);
   assign dwell_end   = (state == SCAN_ON) && (dwell == DWELL_LAST);
   assign frame_end   = dwell_end && (col == COL_W'(NUM_COLS - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= SCAN_IDLE;
         dwell       <= '0;
         col         <= '0;
         frame_start <= 1'b0;
      end else begin
         frame_start <= dwell_start && (col == '0);
         if (!enable) begin
            state <= SCAN_IDLE;
            dwell <= '0;
            col   <= '0;
         end else begin
            case (state)
               SCAN_IDLE: begin
                  state <= SCAN_BLANK;
                  dwell <= '0;
                  col   <= '0;
               end
               SCAN_BLANK: begin
                  dwell <= dwell + 1'b1;
                  if (dwell == BLANK_LAST)
                     state <= SCAN_ON;
               end
               SCAN_ON: begin
                  // dwell wraps to 0 here, so the next column starts blanked
                  dwell <= dwell + 1'b1;
                  if (dwell_end) begin
                     state <= SCAN_BLANK;
                     col   <= col + 1'b1;
                  end
               end
               default: state <= SCAN_IDLE;
            endcase
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/matrix_scan_ctrl.sv
// ============================================================================
// matrix_scan_ctrl : double-buffered 8x4 LED matrix scanner with PWM dimming
// Revision         : 1.0
// ============================================================================
`default_nettype none

module matrix_scan_ctrl
   import matrix_pkg::*;
#(
   parameter int DIV_W    = 13,
   parameter int BLANK    = 16,
   parameter int BRIGHT_W = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic                wr_valid,
   output logic                wr_ready,
   input  logic [COL_W-1:0]    wr_col,
   input  logic [NUM_ROWS-1:0] wr_data,
   input  logic                swap,
   input  logic [BRIGHT_W-1:0] brightness,
   output logic [NUM_ROWS-1:0] io_out,
   output logic [NUM_COLS-1:0] io_col,
   output logic                frame_start
);

   scan_state_t         scan_state;
   logic [COL_W-1:0]    scan_col;
   logic [BRIGHT_W-1:0] pwm_phase;
   logic                dwell_start;
   logic                frame_end;

   row_t                shadow      [NUM_COLS];
   row_t                active      [NUM_COLS];
   row_t                shadow_next [NUM_COLS];
   logic                swap_pending;
   logic                pending_next;
   logic                commit;
   logic [BRIGHT_W-1:0] bright_q;
   logic                pwm_on;

   scan_timer #(
      .DIV_W   (DIV_W),
      .BLANK   (BLANK),
      .PHASE_W (BRIGHT_W)
   ) u_timer (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .state       (scan_state),
      .col         (scan_col),
      .phase       (pwm_phase),
      .dwell_start (dwell_start),
      .frame_end   (frame_end),
      .frame_start (frame_start)
   );

   // A same-cycle write is folded into the committed image.
   always_comb begin
      shadow_next = shadow;
      if (wr_valid && wr_ready)
         shadow_next[wr_col] = wr_data;
      commit       = swap_pending && (!enable || frame_end);
      pending_next = swap_pending ? !commit : swap;
      pwm_on       = (pwm_phase <= bright_q);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shadow       <= '{default: '0};
         active       <= '{default: '0};
         swap_pending <= 1'b0;
         wr_ready     <= 1'b1;
         bright_q     <= '0;
         io_out       <= '1;
         io_col       <= '1;
      end else begin
         shadow       <= shadow_next;
         if (commit)
            active <= shadow_next;
         swap_pending <= pending_next;
         wr_ready     <= !pending_next;
         if (dwell_start)
            bright_q <= brightness;
         if (scan_state == SCAN_ON) begin
            io_col <= ~(NUM_COLS'(1) << scan_col);
            io_out <= ~(active[scan_col] & {NUM_ROWS{pwm_on}});
         end else begin
            io_col <= '1;
            io_out <= '1;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_matrix_scan_ctrl.sv
// ============================================================================
// tb_matrix_scan_ctrl : scoreboard bench with a frame-position reference model
// Revision            : 1.0
// ============================================================================
`default_nettype none

module tb_matrix_scan_ctrl;

   localparam int DIV_W    = 6;
   localparam int BLANK    = 4;
   localparam int BRIGHT_W = 3;
   localparam int DWELL    = 1 << DIV_W;
   localparam int FRAME    = 4 * DWELL;
   localparam int PWM_LEN  = 1 << BRIGHT_W;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic       wr_valid = 1'b0;
   logic       swap = 1'b0;
   logic [1:0] wr_col = 2'd0;
   logic [7:0] wr_data = 8'd0;
   logic [2:0] brightness = 3'd0;
   logic       wr_ready;
   logic       frame_start;
   logic [7:0] io_out;
   logic [3:0] io_col;

   matrix_scan_ctrl #(
      .DIV_W    (DIV_W),
      .BLANK    (BLANK),
      .BRIGHT_W (BRIGHT_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .wr_col      (wr_col),
      .wr_data     (wr_data),
      .swap        (swap),
      .brightness  (brightness),
      .io_out      (io_out),
      .io_col      (io_col),
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] io_out;
      logic [3:0] io_col;
      logic       fs;
      logic       rdy;
   } exp_t;

   exp_t expq[$];
   int   tests = 0;
   int   fails = 0;

   // Model: p = cycles since scanning started (-1 when idle).
   int         p = -1;
   logic [7:0] m_shadow [4];
   logic [7:0] m_active [4];
   bit         m_pending = 1'b0;
   int         m_bq = 0;

   task automatic model_reset();
      p         = -1;
      m_pending = 1'b0;
      m_bq      = 0;
      for (int i = 0; i < 4; i++) begin
         m_shadow[i] = 8'h00;
         m_active[i] = 8'h00;
      end
   endtask

   // One clock: drive inputs, advance the model, queue the pins expected after the edge.
   task automatic cyc(input bit en, input bit wv, input int wc, input logic [7:0] wd,
                      input bit sw, input int br, input bit rst);
      exp_t e;
      bit   commit;
      int   c;
      @(negedge clk);
      reset      = rst;
      enable     = en;
      wr_valid   = wv;
      wr_col     = wc[1:0];
      wr_data    = wd;
      swap       = sw;
      brightness = br[2:0];
      if (rst) begin
         model_reset();
         e = '{io_out: 8'hFF, io_col: 4'hF, fs: 1'b0, rdy: 1'b1};
      end else begin
         if (p < 0 || (p % DWELL) < BLANK) begin
            e.io_out = 8'hFF;
            e.io_col = 4'hF;
         end else begin
            c        = (p / DWELL) % 4;
            e.io_col = ~(4'b0001 << c);
            e.io_out = ((p % PWM_LEN) <= m_bq) ? ~m_active[c] : 8'hFF;
         end
         e.fs = (p >= 0) && (p % FRAME == 0);
         if (wv && !m_pending)
            m_shadow[wc[1:0]] = wd;
         commit = m_pending && (!en || (p >= 0 && p % FRAME == FRAME - 1));
         if (commit)
            m_active = m_shadow;
         m_pending = m_pending ? !commit : sw;
         e.rdy     = !m_pending;
         if (p >= 0 && p % DWELL == 0)
            m_bq = br;
         p = en ? p + 1 : -1;
      end
      expq.push_back(e);
      if (rst) begin
         #1;
         tests++;
         if (io_out !== 8'hFF || io_col !== 4'hF) begin
            fails++;
            $display("FAIL async_reset @%0t: got out=%h col=%h, want out=ff col=f",
                     $time, io_out, io_col);
         end
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (expq.size() > 0) begin
            e = expq.pop_front();
            tests++;
            if ({io_out, io_col, frame_start, wr_ready} !== e) begin
               fails++;
               $display("FAIL pins @%0t: got out=%h col=%h fs=%b rdy=%b, want out=%h col=%h fs=%b rdy=%b",
                        $time, io_out, io_col, frame_start, wr_ready,
                        e.io_out, e.io_col, e.fs, e.rdy);
            end
         end
      end
   end

   initial begin : stimulus
      int guard;
      bit ren;
      model_reset();

      repeat (3) cyc(0, 0, 0, 8'h00, 0, 0, 1);
      repeat (2) cyc(0, 0, 0, 8'h00, 0, 0, 0);

      // Enable and scan one full frame plus the start of the next
      repeat (270) cyc(1, 0, 0, 8'h00, 0, 3, 0);

      // Write col 2, swap, then hold a col-0 write that must wait for wr_ready
      cyc(1, 1, 2, 8'hA5, 0, 7, 0);
      cyc(1, 0, 0, 8'h00, 1, 7, 0);
      repeat (400) cyc(1, 1, 0, 8'h01, 0, 7, 0);
      repeat (300) cyc(1, 0, 0, 8'h00, 0, 7, 0);

      // Write and swap in the same cycle
      cyc(1, 1, 1, 8'hFF, 1, 7, 0);
      repeat (600) cyc(1, 0, 0, 8'h00, 0, 7, 0);

      // PWM at level 1, then full level
      cyc(1, 1, 0, 8'h01, 0, 1, 0);
      cyc(1, 0, 0, 8'h00, 1, 1, 0);
      repeat (600) cyc(1, 0, 0, 8'h00, 0, 1, 0);
      repeat (300) cyc(1, 0, 0, 8'h00, 0, 7, 0);

      // Disable mid-scan, commit while disabled, re-enable from column 0
      repeat (50) cyc(1, 0, 0, 8'h00, 0, 7, 0);
      repeat (3) cyc(0, 0, 0, 8'h00, 0, 7, 0);
      cyc(0, 1, 3, 8'h3C, 0, 7, 0);
      cyc(0, 0, 0, 8'h00, 1, 7, 0);
      repeat (5) cyc(0, 0, 0, 8'h00, 0, 7, 0);
      repeat (300) cyc(1, 0, 0, 8'h00, 0, 7, 0);

      // Asynchronous reset in the middle of an ON phase
      guard = 0;
      while (!(p >= 0 && p % DWELL == 30) && guard < 400) begin
         cyc(1, 0, 0, 8'h00, 0, 7, 0);
         guard++;
      end
      cyc(1, 0, 0, 8'h00, 0, 7, 1);
      cyc(1, 0, 0, 8'h00, 0, 7, 1);
      repeat (300) cyc(1, 0, 0, 8'h00, 0, 7, 0);

      // Randomized traffic
      ren = 1'b1;
      repeat (5000) begin
         if ($urandom_range(0, 399) == 0)
            ren = !ren;
         cyc(ren, ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)), 8'($urandom),
             ($urandom_range(0, 99) == 0), int'($urandom_range(0, 7)), 0);
      end

      @(posedge clk);
      #2;
      tests++;
      if (expq.size() != 0) begin
         fails++;
         $display("FAIL drain: got %0d queued expectations, want 0", expq.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
